// File: rtl/irq_controller_pkg.sv
// Shared SoC definitions for the interrupt controller: bus widths, register
// offsets, FSM state encoding and the ACTIVE register layout.
package irq_controller_pkg;

  localparam int unsigned NUM_IRQ_MAX = 8;
  localparam int unsigned ID_W        = $clog2(NUM_IRQ_MAX);
  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 32;

  // Block base in the SoC map; only the upper half identifies the block.
  localparam logic [31:0] SOC_BASE    = 32'h4002_0000;

  localparam logic [7:0] OFF_ENABLE  = 8'h00;
  localparam logic [7:0] OFF_PENDING = 8'h04;
  localparam logic [7:0] OFF_ACTIVE  = 8'h08;
  localparam logic [7:0] OFF_SWTRIG  = 8'h0C;
  localparam logic [7:0] OFF_EOI     = 8'h10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } irq_state_e;

  typedef struct packed {
    logic                     valid;
    logic [DATA_W-ID_W-2:0]   rsvd;
    logic [ID_W-1:0]          id;
  } active_reg_t;

  // True when a full 32-bit SoC address falls in this block's window.
  function automatic logic soc_hit(input logic [31:0] full_addr);
    return full_addr[31:16] == SOC_BASE[31:16];
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index priority encoder.
//   req : request vector, bit 0 has highest priority
//   id  : index of the lowest set request bit (0 when none)
//   any : at least one request bit is set
module irq_prio_enc
  import irq_controller_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    id  = '0;
    any = 1'b0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        id  = ID_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge-detects level sources into a
// pending register, arbitrates lowest index first, and runs a
// request/acknowledge/end-of-interrupt handshake with the CPU.
//   clk, reset_n          : clock, async active-low reset
//   addr, data_in         : bus address (addr[7:0] decoded) and write data
//   write_enable          : qualified write strobe
//   read_enable           : qualified read strobe
//   data_out, ready       : registered read data and access-complete pulse
//   irq_in                : level interrupt sources
//   interrupt             : request to the CPU (high only while requesting)
//   interrupt_ack         : CPU acknowledge pulse
//   src_ack               : one-cycle acknowledge to the serviced source
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]  data_out,
  input  logic               write_enable,
  input  logic               read_enable,
  output logic               ready,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               interrupt,
  input  logic               interrupt_ack,
  output logic [NUM_IRQ-1:0] src_ack
);

  logic [7:0]         reg_off;
  logic               wr_enable, wr_pending, wr_swtrig, wr_eoi;
  logic [NUM_IRQ-1:0] wdata;
  logic [NUM_IRQ-1:0] enable_q, pending_q, irq_prev_q;
  logic [NUM_IRQ-1:0] req_vec, sel_vec, ack_vec, set_vec, clr_vec, pending_d;
  logic [ID_W-1:0]    arb_id, active_id_q;
  logic               arb_any, active_valid_q, ack_take, sel_live;
  irq_state_e         state_q;
  active_reg_t        active_reg;
  logic [DATA_W-1:0]  rd_data;
  logic               unused_bits;

  // Register decode
  assign reg_off    = addr[7:0];
  assign wdata      = data_in[NUM_IRQ-1:0];
  assign wr_enable  = write_enable && (reg_off == OFF_ENABLE);
  assign wr_pending = write_enable && (reg_off == OFF_PENDING);
  assign wr_swtrig  = write_enable && (reg_off == OFF_SWTRIG);
  assign wr_eoi     = write_enable && (reg_off == OFF_EOI);
  assign unused_bits = ^{addr[ADDR_W-1:8], data_in};

  // Pending update: sets are applied after clears so a same-cycle set wins
  assign req_vec   = pending_q & enable_q;
  assign sel_vec   = NUM_IRQ'(1) << active_id_q;
  assign ack_take  = (state_q == ST_REQ) && interrupt_ack;
  assign ack_vec   = ack_take ? sel_vec : '0;
  assign sel_live  = |(pending_q & enable_q & sel_vec);
  assign set_vec   = (irq_in & ~irq_prev_q) | (wr_swtrig ? wdata : '0);
  assign clr_vec   = (wr_pending ? wdata : '0) | ack_vec;
  assign pending_d = (pending_q & ~clr_vec) | set_vec;

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
    .req (req_vec),
    .id  (arb_id),
    .any (arb_any)
  );

  // Read mux
  always_comb begin
    active_reg       = '0;
    active_reg.valid = active_valid_q;
    active_reg.id    = active_id_q;
    rd_data          = '0;
    case (reg_off)
      OFF_ENABLE:  rd_data[NUM_IRQ-1:0] = enable_q;
      OFF_PENDING: rd_data[NUM_IRQ-1:0] = pending_q;
      OFF_ACTIVE:  rd_data = DATA_W'(active_reg);
      default:     rd_data = '0;
    endcase
  end

  // Registers, bus response and request/ack/EOI state machine
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q       <= '0;
      pending_q      <= '0;
      irq_prev_q     <= '0;
      active_id_q    <= '0;
      active_valid_q <= 1'b0;
      data_out       <= '0;
      ready          <= 1'b0;
      interrupt      <= 1'b0;
      src_ack        <= '0;
      state_q        <= ST_IDLE;
    end else begin
      ready      <= read_enable | write_enable;
      data_out   <= read_enable ? rd_data : '0;
      irq_prev_q <= irq_in;
      pending_q  <= pending_d;
      src_ack    <= ack_vec;
      interrupt  <= 1'b0;
      if (wr_enable) enable_q <= wdata;

      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            active_id_q <= arb_id;
            state_q     <= ST_REQ;
            interrupt   <= 1'b1;
          end
        end
        ST_REQ: begin
          // Acknowledge beats a withdrawn request
          if (interrupt_ack) begin
            active_valid_q <= 1'b1;
            state_q        <= ST_ACTIVE;
          end else if (!sel_live) begin
            state_q <= ST_IDLE;
          end else begin
            interrupt <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (wr_eoi) begin
            active_valid_q <= 1'b0;
            state_q        <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios followed by a
// randomized run compared against a cycle-level behavioural model.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        write_enable;
  logic        read_enable;
  logic        ready;
  logic [7:0]  irq_in;
  logic        interrupt;
  logic        interrupt_ack;
  logic [7:0]  src_ack;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  localparam int PH_IDLE = 0, PH_REQ = 1, PH_ACTIVE = 2;
  logic [7:0]  m_en, m_pend, m_prev, m_srcack;
  logic [2:0]  m_id;
  int          m_phase;
  logic        m_valid, m_int, m_ready;
  logic [31:0] m_dout;

  irq_controller #(.NUM_IRQ(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .addr          (addr),
    .data_in       (data_in),
    .data_out      (data_out),
    .write_enable  (write_enable),
    .read_enable   (read_enable),
    .ready         (ready),
    .irq_in        (irq_in),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .src_ack       (src_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    addr = '0; data_in = '0; write_enable = 0; read_enable = 0; interrupt_ack = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
  endtask

  task automatic bus_write(input logic [7:0] off, input logic [31:0] d);
    addr = {8'h00, off}; data_in = d; write_enable = 1;
    tick();
    write_enable = 0; data_in = '0;
  endtask

  // Returns the read value plus ready during and one cycle after the pulse.
  task automatic bus_read(input logic [7:0] off, output logic [31:0] v,
                          output logic rdy_pulse, output logic rdy_after,
                          output logic [31:0] dout_after);
    addr = {8'h00, off}; read_enable = 1;
    tick();
    read_enable = 0;
    v = data_out; rdy_pulse = ready;
    tick();
    rdy_after = ready; dout_after = data_out;
  endtask

  task automatic ack_pulse();
    interrupt_ack = 1;
    tick();
    interrupt_ack = 0;
  endtask

  task automatic wait_int(output bit ok);
    ok = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (interrupt === 1'b1) ok = 1;
      else tick();
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] v, da; logic rp, ra;
    irq_in = 0;
    idle_inputs();
    reset_n = 0;
    tick();
    checks++;
    if ({interrupt, ready, src_ack, data_out} !== 42'd0) begin
      errors++; $display("FAIL reset_outputs: got int=%b rdy=%b src_ack=%h dout=%h, expected all 0",
                         interrupt, ready, src_ack, data_out);
    end
    reset_n = 1;
    tick();
    bus_read(8'h00, v, rp, ra, da);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_enable: got %h expected 0", v); end
    bus_read(8'h04, v, rp, ra, da);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_pending: got %h expected 0", v); end
    bus_read(8'h08, v, rp, ra, da);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_active: got %h expected 0", v); end
  endtask

  task automatic test_basic();
    logic [31:0] v, da; logic rp, ra;
    apply_reset();
    irq_in = 0;
    bus_write(8'h00, 32'h01);
    tick();
    irq_in[0] = 1;
    tick();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL basic_latency1: got int=%b expected 0", interrupt); end
    tick();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL basic_latency2: got int=%b expected 1", interrupt); end
    ack_pulse();
    checks++;
    if (src_ack !== 8'h01 || interrupt !== 1'b0) begin
      errors++; $display("FAIL basic_ack: got src_ack=%h int=%b expected 01/0", src_ack, interrupt);
    end
    tick();
    checks++; if (src_ack !== 8'h00) begin errors++; $display("FAIL basic_src_ack_width: got %h expected 00", src_ack); end
    bus_read(8'h04, v, rp, ra, da);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL basic_pending: got %h expected 0", v); end
    bus_read(8'h08, v, rp, ra, da);
    checks++; if (v !== 32'h8000_0000) begin errors++; $display("FAIL basic_active: got %h expected 80000000", v); end
  endtask

  task automatic test_priority();
    logic [31:0] v, da; logic rp, ra; bit ok;
    apply_reset();
    irq_in = 0;
    bus_write(8'h00, 32'hFF);
    bus_write(8'h0C, 32'h28);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL prio_early: got int=%b expected 0", interrupt); end
    tick();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL prio_req: got int=%b expected 1", interrupt); end
    ack_pulse();
    checks++; if (src_ack !== 8'h08) begin errors++; $display("FAIL prio_first_ack: got %h expected 08", src_ack); end
    bus_read(8'h08, v, rp, ra, da);
    checks++; if (v !== 32'h8000_0003) begin errors++; $display("FAIL prio_first_id: got %h expected 80000003", v); end
    bus_write(8'h10, 32'h0);
    wait_int(ok);
    checks++; if (!ok) begin errors++; $display("FAIL prio_reassert: got int=%b expected 1 (timeout)", interrupt); end
    ack_pulse();
    checks++; if (src_ack !== 8'h20) begin errors++; $display("FAIL prio_second_ack: got %h expected 20", src_ack); end
    bus_read(8'h08, v, rp, ra, da);
    checks++; if (v !== 32'h8000_0005) begin errors++; $display("FAIL prio_second_id: got %h expected 80000005", v); end
    bus_write(8'h10, 32'h0);
    bus_read(8'h04, v, rp, ra, da);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL prio_pending_empty: got %h expected 0", v); end
  endtask

  task automatic test_withdraw();
    logic [31:0] v, da; logic rp, ra; bit ok; logic [7:0] acc_ack;
    apply_reset();
    irq_in = 0;
    bus_write(8'h00, 32'hFF);
    bus_write(8'h0C, 32'h04);
    wait_int(ok);
    checks++; if (!ok) begin errors++; $display("FAIL withdraw_req: got int=%b expected 1 (timeout)", interrupt); end
    bus_write(8'h04, 32'h04);
    acc_ack = src_ack;
    tick();
    acc_ack |= src_ack;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL withdraw_drop: got int=%b expected 0", interrupt); end
    tick(); acc_ack |= src_ack;
    tick(); acc_ack |= src_ack;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL withdraw_no_rearb: got int=%b expected 0", interrupt); end
    checks++; if (acc_ack !== 8'h00) begin errors++; $display("FAIL withdraw_src_ack: got %h expected 00", acc_ack); end
    // A late ack outside REQ must be ignored
    ack_pulse();
    checks++; if (src_ack !== 8'h00) begin errors++; $display("FAIL withdraw_stray_ack: got %h expected 00", src_ack); end
    bus_read(8'h08, v, rp, ra, da);
    checks++; if (v[31] !== 1'b0) begin errors++; $display("FAIL withdraw_valid: got %b expected 0", v[31]); end
  endtask

  task automatic test_set_wins();
    logic [31:0] v, da; logic rp, ra;
    apply_reset();
    irq_in = 0;
    bus_write(8'h0C, 32'h02);
    irq_in[1] = 1;
    bus_write(8'h04, 32'h02);
    bus_read(8'h04, v, rp, ra, da);
    checks++; if (v !== 32'h02) begin errors++; $display("FAIL set_wins: got %h expected 00000002", v); end
    bus_write(8'h04, 32'h02);
    bus_read(8'h04, v, rp, ra, da);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL w1c_plain: got %h expected 0", v); end
  endtask

  task automatic test_async_reset();
    logic [31:0] v, da; logic rp, ra; bit ok; bit quiet;
    apply_reset();
    irq_in = 0;
    bus_write(8'h00, 32'hFF);
    bus_write(8'h0C, 32'h01);
    wait_int(ok);
    checks++; if (!ok) begin errors++; $display("FAIL areset_req: got int=%b expected 1 (timeout)", interrupt); end
    #2 reset_n = 0;
    #1;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL areset_mid_req: got int=%b expected 0", interrupt); end
    tick();
    reset_n = 1;
    bus_write(8'h00, 32'hFF);
    bus_write(8'h0C, 32'h01);
    wait_int(ok);
    ack_pulse();
    bus_write(8'h0C, 32'h10);
    tick();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL active_no_nest: got int=%b expected 0", interrupt); end
    bus_read(8'h04, v, rp, ra, da);
    checks++; if (v !== 32'h10) begin errors++; $display("FAIL active_accumulate: got %h expected 00000010", v); end
    #2 reset_n = 0;
    #1;
    checks++; if (interrupt !== 1'b0 || src_ack !== 8'h0) begin
      errors++; $display("FAIL areset_mid_active: got int=%b src_ack=%h expected 0/00", interrupt, src_ack);
    end
    tick();
    reset_n = 1;
    bus_read(8'h00, v, rp, ra, da);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL areset_enable: got %h expected 0", v); end
    bus_read(8'h04, v, rp, ra, da);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL areset_pending: got %h expected 0", v); end
    bus_read(8'h08, v, rp, ra, da);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL areset_active: got %h expected 0", v); end
    bus_write(8'h00, 32'h10);
    quiet = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (interrupt !== 1'b0) quiet = 0;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL areset_quiet: got int=1 expected 0 before new edge"); end
    irq_in[4] = 1;
    tick();
    tick();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL areset_new_edge: got int=%b expected 1", interrupt); end
  endtask

  task automatic test_reset_history();
    logic [31:0] v, da; logic rp, ra;
    irq_in = 8'h08;
    apply_reset();
    tick();
    bus_read(8'h04, v, rp, ra, da);
    checks++; if (v !== 32'h08) begin errors++; $display("FAIL reset_history: got %h expected 00000008", v); end
    irq_in = 0;
  endtask

  task automatic test_unmapped();
    logic [31:0] v, da; logic rp, ra;
    apply_reset();
    irq_in = 0;
    bus_write(8'h00, 32'hA5);
    bus_write(8'h1C, 32'hFFFF_FFFF);
    bus_read(8'h1C, v, rp, ra, da);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_data: got %h expected 0", v); end
    checks++; if (rp !== 1'b1 || ra !== 1'b0 || da !== 32'h0) begin
      errors++; $display("FAIL unmapped_ready: got pulse=%b after=%b dout_after=%h expected 1/0/0", rp, ra, da);
    end
    // Only addr[7:0] is decoded: an upper-byte alias reaches ENABLE
    addr = 16'hAB00; read_enable = 1;
    tick();
    read_enable = 0;
    checks++; if (data_out !== 32'hA5 || ready !== 1'b1) begin
      errors++; $display("FAIL alias_enable: got %h rdy=%b expected 000000a5/1", data_out, ready);
    end
    tick();
  endtask

  // ---------------------------------------------------------------------
  // Model: one call per clock edge, with the inputs that are in force.
  task automatic model_step(input logic [7:0] irq, input logic we, input logic re,
                            input logic [7:0] off, input logic [31:0] d, input logic ack);
    logic [7:0] set_m, clr_m, ready_req;
    logic [31:0] rd;
    int lowest;
    rd = 0;
    if (off == 8'h00) rd = {24'd0, m_en};
    else if (off == 8'h04) rd = {24'd0, m_pend};
    else if (off == 8'h08) rd = {m_valid, 28'd0, m_id};
    m_ready = we | re;
    m_dout  = re ? rd : 32'd0;
    set_m = irq & ~m_prev;
    if (we && off == 8'h0C) set_m = set_m | d[7:0];
    clr_m = (we && off == 8'h04) ? d[7:0] : 8'h00;
    m_srcack = 0;
    m_int = 0;
    ready_req = m_pend & m_en;
    if (m_phase == PH_IDLE) begin
      lowest = -1;
      for (int i = 7; i >= 0; i--) if (ready_req[i]) lowest = i;
      if (lowest >= 0) begin
        m_id = 3'(lowest); m_phase = PH_REQ; m_int = 1;
      end
    end else if (m_phase == PH_REQ) begin
      if (ack) begin
        clr_m = clr_m | (8'h01 << m_id);
        m_srcack = 8'h01 << m_id;
        m_valid = 1; m_phase = PH_ACTIVE;
      end else if (ready_req[m_id] == 1'b0) begin
        m_phase = PH_IDLE;
      end else begin
        m_int = 1;
      end
    end else begin
      if (we && off == 8'h10) begin
        m_valid = 0; m_phase = PH_IDLE;
      end
    end
    m_pend = (m_pend & ~clr_m) | set_m;
    m_prev = irq;
    if (we && off == 8'h00) m_en = d[7:0];
  endtask

  task automatic test_random();
    logic [7:0] offs [6];
    logic [7:0] off;
    int op;
    offs[0] = 8'h00; offs[1] = 8'h04; offs[2] = 8'h08;
    offs[3] = 8'h0C; offs[4] = 8'h10; offs[5] = 8'h1C;
    irq_in = 0;
    apply_reset();
    m_en = 0; m_pend = 0; m_prev = 0; m_id = 0; m_phase = PH_IDLE;
    m_valid = 0; m_int = 0; m_ready = 0; m_dout = 0; m_srcack = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      irq_in = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      write_enable = 0; read_enable = 0;
      op = int'($urandom_range(0, 9));
      off = offs[$urandom_range(0, 5)];
      data_in = $urandom;
      case (op)
        3, 4: read_enable = 1;
        5: begin write_enable = 1; off = 8'h00; end
        6: begin write_enable = 1; off = 8'h04; end
        7: begin write_enable = 1; off = 8'h0C; data_in = data_in & $urandom & $urandom; end
        8: begin write_enable = 1; off = 8'h10; end
        9: begin write_enable = 1; off = 8'h1C; end
        default: ;
      endcase
      addr = {8'($urandom), off};
      interrupt_ack = (interrupt === 1'b1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      model_step(irq_in, write_enable, read_enable, off, data_in, interrupt_ack);
      tick();
      checks++;
      if (interrupt !== m_int) begin errors++; $display("FAIL rand_interrupt cyc=%0d: got %b expected %b", cyc, interrupt, m_int); end
      checks++;
      if (src_ack !== m_srcack) begin errors++; $display("FAIL rand_src_ack cyc=%0d: got %h expected %h", cyc, src_ack, m_srcack); end
      checks++;
      if (ready !== m_ready) begin errors++; $display("FAIL rand_ready cyc=%0d: got %b expected %b", cyc, ready, m_ready); end
      checks++;
      if (data_out !== m_dout) begin errors++; $display("FAIL rand_data_out cyc=%0d: got %h expected %h", cyc, data_out, m_dout); end
    end
    idle_inputs();
  endtask

  initial begin
    reset_n = 0;
    irq_in = 0;
    idle_inputs();
    test_reset();
    test_basic();
    test_priority();
    test_withdraw();
    test_set_wins();
    test_async_reset();
    test_reset_history();
    test_unmapped();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
